mc_main_fsm: RTL and testbench

- Main control unit for the multicycle MIPS datapath; replaces the single-cycle combinational main decoder.
- Sequences FETCH/DECODE/execute/writeback states per opcode and drives every non-ALU-function control signal.
- Adds a memory request/ready handshake with a bounded wait timeout and illegal-opcode trapping.
- Supports R-type, LW, SW, BEQ, BNE, ADDI, ORI and J.

---
 rtl/mc_main_fsm.sv | 212 +++++++++++++++++++++
 tb/tb_mc_main_fsm.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_fsm.sv
// Multicycle MIPS main control FSM with memory handshake, timeout and trap.
// Define MC_MAIN_FSM_PERF_EN to enable the retired-instruction counter.
module mc_main_fsm #(
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned TO_CNT_W = 5,
    parameter int unsigned CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             iord,
    output logic             mem_write,
    output logic             ir_write,
    output logic             pc_write,
    output logic             branch,
    output logic             branch_equality,
    output logic [1:0]       pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic             imm_zext,
    output logic [1:0]       alu_op,
    output logic             reg_dest,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_count
);
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [TO_CNT_W-1:0] TO_LAST =
        TO_CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_BRANCH, S_ADDIEX, S_ORIEX, S_IMMWB, S_JUMP, S_FAULT
    } state_t;

    state_t              state_q, state_d;
    logic [TO_CNT_W-1:0] cnt_q, cnt_d;
    logic                ill_q, ill_d;
    logic                to_q, to_d;
    logic                waiting;
    logic                expired;

    assign waiting = (state_q == S_FETCH) || (state_q == S_MEMRD)
                  || (state_q == S_MEMWR);
    assign expired = (TIMEOUT != 0) && waiting && !mem_ready
                  && (cnt_q == TO_LAST);

    always_comb begin
        state_d = state_q;
        ill_d   = ill_q;
        to_d    = to_q;
        unique case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                unique case (op)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_ADDI:       state_d = S_ADDIEX;
                    OP_ORI:        state_d = S_ORIEX;
                    OP_J:          state_d = S_JUMP;
                    default: begin
                        state_d = S_FETCH;
                        ill_d   = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX, S_ORIEX: state_d = S_IMMWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP: state_d = S_FETCH;
            default:  state_d = S_FAULT;
        endcase
        // A completing access in the last wait cycle never reaches here.
        if (expired) begin
            state_d = S_FAULT;
            to_d    = 1'b1;
        end
    end

    always_comb begin
        cnt_d = '0;
        if (waiting && !mem_ready && state_d == state_q)
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            cnt_q   <= '0;
            ill_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ill_q   <= ill_d;
            to_q    <= to_d;
        end
    end

    // Strobes are gated by reset so a pending request drops immediately.
    always_comb begin
        mem_req         = 1'b0;
        iord            = 1'b0;
        mem_write       = 1'b0;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        branch          = 1'b0;
        branch_equality = 1'b0;
        pc_src          = 2'b00;
        alu_src_a       = 1'b0;
        alu_src_b       = 2'b00;
        imm_zext        = 1'b0;
        alu_op          = 2'b00;
        reg_dest        = 1'b0;
        mem_to_reg      = 1'b0;
        reg_write       = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    mem_req   = 1'b1;
                    iord      = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dest  = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a       = 1'b1;
                    alu_op          = 2'b01;
                    pc_src          = 2'b01;
                    branch          = 1'b1;
                    branch_equality = (op == OP_BEQ);
                end
                S_ADDIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_ORIEX: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                    imm_zext  = 1'b1;
                end
                S_IMMWB: reg_write = 1'b1;
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal_op  = ill_q;
    assign mem_timeout = to_q;

`ifdef MC_MAIN_FSM_PERF_EN
    logic [CNT_W-1:0] icnt_q;
    logic             retire;

    assign retire = (state_d == S_FETCH) && (state_q inside
        {S_MEMWB, S_MEMWR, S_ALUWB, S_BRANCH, S_IMMWB, S_JUMP});

    always_ff @(posedge clk or posedge reset) begin
        if (reset)       icnt_q <= '0;
        else if (retire) icnt_q <= icnt_q + 1'b1;
    end

    assign instr_count = icnt_q;
`else
    assign instr_count = '0;
`endif
endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: vector table, directed corner cases and a random
// run checked against a queue-of-steps model of each instruction.
module tb_mc_main_fsm;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned CNT_W   = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic [5:0]       op;
    logic             mem_ready;
    logic             mem_req, iord, mem_write, ir_write, pc_write;
    logic             branch, branch_equality, alu_src_a, imm_zext;
    logic [1:0]       pc_src, alu_src_b, alu_op;
    logic             reg_dest, mem_to_reg, reg_write;
    logic             illegal_op, mem_timeout;
    logic [CNT_W-1:0] instr_count;

    mc_main_fsm #(.TIMEOUT(TIMEOUT), .TO_CNT_W(5), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready),
        .mem_req(mem_req), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .pc_write(pc_write), .branch(branch),
        .branch_equality(branch_equality), .pc_src(pc_src),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_zext(imm_zext), .alu_op(alu_op), .reg_dest(reg_dest),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write),
        .illegal_op(illegal_op), .mem_timeout(mem_timeout),
        .instr_count(instr_count)
    );

    always #5 clk = ~clk;

    typedef enum logic [3:0] {
        T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB, T_MEMWR, T_EXEC,
        T_ALUWB, T_BRANCH, T_ADDI, T_ORI, T_IMMWB, T_JUMP, T_FAULT
    } step_t;

    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       mem_write;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic       beq;
        logic [1:0] pc_src;
        logic       a;
        logic [1:0] b;
        logic       zext;
        logic [1:0] alu_op;
        logic       reg_dest;
        logic       m2r;
        logic       reg_write;
    } ctrl_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        step_t      st;
        logic       ill;
    } vec_t;

    ctrl_t got;
    assign got = {mem_req, iord, mem_write, ir_write, pc_write, branch,
                  branch_equality, pc_src, alu_src_a, alu_src_b, imm_zext,
                  alu_op, reg_dest, mem_to_reg, reg_write};

    int n_checks = 0;
    int n_errors = 0;

    step_t       mq[$];
    int unsigned mwait;
    int unsigned m_ret;
    logic        m_ill, m_to, m_fault;
    vec_t        tab[$];
    logic [5:0]  legal [8] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd13, 6'd2};

    function automatic ctrl_t ctrl_of(step_t s, logic [5:0] o, logic r);
        ctrl_t c = '0;
        case (s)
            T_FETCH:  begin c.mem_req = 1; c.b = 2'b01; c.ir_write = r; c.pc_write = r; end
            T_DECODE: c.b = 2'b11;
            T_MEMADR: begin c.a = 1; c.b = 2'b10; end
            T_MEMRD:  begin c.mem_req = 1; c.iord = 1; end
            T_MEMWB:  begin c.reg_write = 1; c.m2r = 1; end
            T_MEMWR:  begin c.mem_req = 1; c.iord = 1; c.mem_write = 1; end
            T_EXEC:   begin c.a = 1; c.alu_op = 2'b10; end
            T_ALUWB:  begin c.reg_write = 1; c.reg_dest = 1; end
            T_BRANCH: begin
                c.a = 1; c.alu_op = 2'b01; c.pc_src = 2'b01; c.branch = 1;
                c.beq = (o == 6'd4);
            end
            T_ADDI:   begin c.a = 1; c.b = 2'b10; end
            T_ORI:    begin c.a = 1; c.b = 2'b10; c.alu_op = 2'b11; c.zext = 1; end
            T_IMMWB:  c.reg_write = 1;
            T_JUMP:   begin c.pc_src = 2'b10; c.pc_write = 1; end
            default:  c = '0;
        endcase
        return c;
    endfunction

    function automatic logic [CNT_W-1:0] exp_icnt();
`ifdef MC_MAIN_FSM_PERF_EN
        return CNT_W'(m_ret);
`else
        return '0;
`endif
    endfunction

    function automatic void m_reset();
        mq.delete();
        mq.push_back(T_FETCH);
        mwait = 0; m_ret = 0; m_ill = 0; m_to = 0; m_fault = 0;
    endfunction

    // One clock edge of the model: memory steps may stall, others always pop.
    function automatic void m_advance(logic [5:0] o, logic r);
        step_t s;
        logic  known;
        if (m_fault) return;
        s = mq[0];
        if ((s == T_FETCH || s == T_MEMRD || s == T_MEMWR) && !r) begin
            if (TIMEOUT > 0 && mwait == TIMEOUT - 1) begin
                m_to = 1; m_fault = 1;
                mq.delete(); mq.push_back(T_FAULT);
            end else begin
                mwait++;
            end
            return;
        end
        mwait = 0;
        void'(mq.pop_front());
        known = 1;
        if (s == T_FETCH) begin
            mq.push_back(T_DECODE);
            case (o)
                6'd0:       begin mq.push_back(T_EXEC); mq.push_back(T_ALUWB); end
                6'd35:      begin mq.push_back(T_MEMADR); mq.push_back(T_MEMRD); mq.push_back(T_MEMWB); end
                6'd43:      begin mq.push_back(T_MEMADR); mq.push_back(T_MEMWR); end
                6'd4, 6'd5: mq.push_back(T_BRANCH);
                6'd8:       begin mq.push_back(T_ADDI); mq.push_back(T_IMMWB); end
                6'd13:      begin mq.push_back(T_ORI); mq.push_back(T_IMMWB); end
                6'd2:       mq.push_back(T_JUMP);
                default:    known = 0;
            endcase
        end
        if (s == T_DECODE && !(o inside {6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd8, 6'd13, 6'd2}))
            m_ill = 1;
        if (mq.size() == 0) begin
            if (s != T_DECODE) m_ret++;
            mq.push_back(T_FETCH);
        end
        if (!known) mq = mq;
    endfunction

    task automatic chk(input string name, input logic [63:0] g, input logic [63:0] e);
        n_checks++;
        if (g !== e) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, g, e);
        end
    endtask

    task automatic drive(input logic [5:0] o, input logic r);
        op = o;
        mem_ready = r;
        #3;
        chk("ctrl", got, ctrl_of(mq[0], o, r));
        chk("flags", {illegal_op, mem_timeout}, {m_ill, m_to});
        chk("instr_count", instr_count, exp_icnt());
    endtask

    task automatic tick();
        @(posedge clk);
        m_advance(op, mem_ready);
        #1;
    endtask

    task automatic reset_now();
        reset = 1'b1;
        m_reset();
        #1;
        chk("reset_strobes", {mem_req, mem_write, ir_write, pc_write, branch, reg_write}, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("reset_flags", {illegal_op, mem_timeout, instr_count}, 0);
    endtask

    function automatic void add(logic [5:0] o, logic r, step_t s, logic i);
        tab.push_back('{o, r, s, i});
    endfunction

    initial begin
        logic [5:0] rop;
        logic       rrdy;
        int         wr_cycles;
        reset = 1'b1; op = '0; mem_ready = 1'b0;
        m_reset();

        add(0, 1, T_FETCH, 0); add(0, 1, T_DECODE, 0);
        add(0, 1, T_EXEC, 0);  add(0, 1, T_ALUWB, 0);
        add(5, 1, T_FETCH, 0); add(5, 1, T_DECODE, 0); add(5, 1, T_BRANCH, 0);
        add(4, 1, T_FETCH, 0); add(4, 1, T_DECODE, 0); add(4, 1, T_BRANCH, 0);
        add(13, 1, T_FETCH, 0); add(13, 1, T_DECODE, 0);
        add(13, 1, T_ORI, 0);   add(13, 1, T_IMMWB, 0);
        add(8, 1, T_FETCH, 0); add(8, 1, T_DECODE, 0);
        add(8, 1, T_ADDI, 0);  add(8, 1, T_IMMWB, 0);
        add(2, 1, T_FETCH, 0); add(2, 1, T_DECODE, 0); add(2, 1, T_JUMP, 0);
        add(35, 0, T_FETCH, 0); add(35, 0, T_FETCH, 0); add(35, 0, T_FETCH, 0);
        add(35, 1, T_FETCH, 0); add(35, 1, T_DECODE, 0); add(35, 1, T_MEMADR, 0);
        add(35, 0, T_MEMRD, 0); add(35, 0, T_MEMRD, 0); add(35, 1, T_MEMRD, 0);
        add(35, 1, T_MEMWB, 0);
        add(43, 1, T_FETCH, 0); add(43, 1, T_DECODE, 0); add(43, 1, T_MEMADR, 0);
        add(43, 0, T_MEMWR, 0); add(43, 1, T_MEMWR, 0);
        add(63, 1, T_FETCH, 0); add(63, 1, T_DECODE, 0);
        add(0, 1, T_FETCH, 1); add(0, 1, T_DECODE, 1);
        add(0, 1, T_EXEC, 1);  add(0, 1, T_ALUWB, 1);
        add(0, 0, T_FETCH, 1);

        reset_now();
        foreach (tab[i]) begin
            drive(tab[i].op, tab[i].rdy);
            chk("table_ctrl", got, ctrl_of(tab[i].st, tab[i].op, tab[i].rdy));
            chk("table_illegal", illegal_op, tab[i].ill);
            tick();
        end

        // SW stalled past the limit ends in FAULT.
        reset_now();
        drive(43, 1); tick(); drive(43, 1); tick(); drive(43, 1); tick();
        wr_cycles = 0;
        for (int i = 0; i < 16; i++) begin
            drive(43, 0);
            if (mem_write) wr_cycles++;
            tick();
        end
        chk("timeout_wait_cycles", wr_cycles, 16);
        drive(43, 1);
        chk("timeout_fault", {mem_timeout, mem_req, mem_write, ir_write,
                              pc_write, branch, reg_write}, 7'b1000000);
        tick();
        drive(43, 1);
        tick();

        // Ready on the last allowed wait cycle completes the store.
        reset_now();
        drive(43, 1); tick(); drive(43, 1); tick(); drive(43, 1); tick();
        for (int i = 0; i < 15; i++) begin
            drive(43, 0);
            tick();
        end
        drive(43, 1);
        tick();
        drive(0, 0);
        chk("no_timeout", {mem_timeout, mem_req, iord}, 3'b010);
        tick();

        // Reset in the middle of a load wait.
        reset_now();
        drive(35, 1); tick(); drive(35, 1); tick(); drive(35, 1); tick();
        drive(35, 0);
        chk("memrd_req", {mem_req, iord}, 2'b11);
        reset = 1'b1;
        #1;
        chk("reset_memreq_drop", mem_req, 0);
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        drive(0, 0);
        chk("after_reset_fetch", {mem_req, iord, illegal_op, mem_timeout}, 4'b1000);
        tick();

        // Random run against the model.
        reset_now();
        rop = '0;
        for (int c = 0; c < 4000; c++) begin
            if (m_fault || $urandom_range(0, 599) == 0) reset_now();
            if (mq[0] == T_FETCH) begin
                if ($urandom_range(0, 19) < 17) rop = legal[$urandom_range(0, 7)];
                else rop = 6'($urandom_range(0, 63));
            end
            rrdy = ($urandom_range(0, 3) != 0);
            drive(rop, rrdy);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
